diff_word_packer: RTL and testbench



---
 rtl/diff_pkg.sv | 16 +
 rtl/pkt_out_slot.sv | 38 +++
 rtl/diff_word_packer.sv | 91 +++++++++
 tb/tb_diff_word_packer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/diff_pkg.sv
// Shared constants and helpers for the diff readback word packer.
// The default width/depth reproduce the legacy 16-bit x 32-word (512-bit) packet.
package diff_pkg;

  localparam int DIFF_IN_W  = 16;
  localparam int DIFF_WORDS = 32;

  // Bits needed to hold values 0..n-1.
  function automatic int diff_clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/pkt_out_slot.sv
// Single output holding register for a finished packet.
// valid/ready: a packet transfers on a cycle where out_valid && out_ready; data and count hold until then.
module pkt_out_slot
  import diff_pkg::*;
#(
  parameter int DW = DIFF_IN_W * DIFF_WORDS,
  parameter int CW = diff_clog2(DIFF_WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic [CW-1:0] load_count,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] out_count,
  output logic          out_valid,
  output logic          slot_free
);

  // A load is only issued when the slot is empty or draining this cycle.
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_count <= '0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_count <= load_count;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/diff_word_packer.sv
// Packs IN_W-bit words into WORDS-word packets with flush-driven zero-padded partial packets.
// valid/ready on both sides: a word moves when in_valid && in_ready, a packet when out_valid && out_ready.
module diff_word_packer
  import diff_pkg::*;
#(
  parameter int IN_W       = DIFF_IN_W,
  parameter int WORDS      = DIFF_WORDS,
  parameter bit NEWEST_LOW = 1'b1,
  parameter bit EMIT_EMPTY = 1'b0,
  parameter int CW         = diff_clog2(WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [IN_W*WORDS-1:0] out_data,
  output logic [CW-1:0]         out_count,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int ACC_W = IN_W * WORDS;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
  localparam logic [CW-1:0] FULL = CW'(WORDS);

  logic [ACC_W-1:0] acc, acc_post;
  logic [CW-1:0]    cnt, cnt_post;
  logic             flush_pend, flush_req, slot_free;
  logic             accept, complete, close, load;

  // The last word of a packet needs somewhere to go, so it waits for the slot.
  assign in_ready  = !flush_pend && (cnt < LAST || slot_free);
  assign accept    = in_valid && in_ready;
  assign flush_req = flush || flush_pend;

  // Accumulator contents after this cycle's word, if any.
  always_comb begin
    acc_post = acc;
    cnt_post = cnt;
    if (accept) begin
      if (NEWEST_LOW) begin
        acc_post = {acc[ACC_W-IN_W-1:0], in_data};
      end else begin
        for (int k = 0; k < WORDS; k++) begin
          if (cnt == CW'(k)) acc_post[k*IN_W +: IN_W] = in_data;
        end
      end
      cnt_post = cnt + CW'(1);
    end
  end

  // A completing word takes priority; a coincident flush stays pending and closes an empty packet next.
  assign complete = (cnt_post == FULL);
  assign close    = !complete && flush_req && slot_free;
  assign load     = complete || (close && (cnt_post != '0 || EMIT_EMPTY));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else if (complete || close) begin
      acc        <= '0;
      cnt        <= '0;
      flush_pend <= complete && flush;
    end else begin
      acc        <= acc_post;
      cnt        <= cnt_post;
      flush_pend <= flush_req;
    end
  end

  pkt_out_slot #(
    .DW(ACC_W),
    .CW(CW)
  ) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (acc_post),
    .load_count(cnt_post),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .slot_free (slot_free)
  );

endmodule

// File: tb/tb_diff_word_packer.sv
// Bench for diff_word_packer: three configurations checked by directed sequences, a vector table,
// and a queue-based packet model that follows every instance on every cycle.
module tb_diff_word_packer;

  localparam int PW = 518;  // {count[5:0], data[511:0]}

  typedef struct {
    int          n;
    bit          fl_last;
    bit          fl_after;
    logic [31:0] exp_data;
    logic [5:0]  exp_cnt;
  } row_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fl   [3];
  logic        iv   [3];
  logic        ordy [3];
  logic [15:0] id   [3];
  wire         ir   [3];
  wire         ov   [3];
  wire [511:0] od   [3];
  wire [5:0]   oc   [3];
  wire [31:0]  od_s;
  wire [2:0]   oc_s;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [PW-1:0] exp_q [3][$];
  logic [15:0] mw  [3][32];
  int          mn  [3];
  logic        mfp [3];

  always #5 clk = ~clk;

  // u0: defaults. u1: oldest-low, emit-empty. u2: 8-bit x 4 words, newest-low, emit-empty.
  diff_word_packer u0 (
    .clk(clk), .rst(rst), .flush(fl[0]), .in_data(id[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .out_data(od[0]), .out_count(oc[0]), .out_valid(ov[0]), .out_ready(ordy[0])
  );
  diff_word_packer #(.NEWEST_LOW(1'b0), .EMIT_EMPTY(1'b1)) u1 (
    .clk(clk), .rst(rst), .flush(fl[1]), .in_data(id[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .out_data(od[1]), .out_count(oc[1]), .out_valid(ov[1]), .out_ready(ordy[1])
  );
  diff_word_packer #(.IN_W(8), .WORDS(4), .NEWEST_LOW(1'b1), .EMIT_EMPTY(1'b1)) u2 (
    .clk(clk), .rst(rst), .flush(fl[2]), .in_data(id[2][7:0]), .in_valid(iv[2]), .in_ready(ir[2]),
    .out_data(od_s), .out_count(oc_s), .out_valid(ov[2]), .out_ready(ordy[2])
  );
  assign od[2] = {480'b0, od_s};
  assign oc[2] = {3'b0, oc_s};

  function automatic int iw(input int i); return (i == 2) ? 8 : 16; endfunction
  function automatic int nw(input int i); return (i == 2) ? 4 : 32; endfunction
  function automatic bit nl(input int i); return (i != 1); endfunction
  function automatic bit ee(input int i); return (i != 0); endfunction

  task automatic chk(input int i, input string nm, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL u%0d %s got=%0h exp=%0h", i, nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Packet built from the words collected so far: valid words in slots 0..n-1, zeros above.
  function automatic logic [PW-1:0] make_pkt(input int i);
    logic [511:0] d;
    logic [15:0]  wd;
    int           n;
    d = '0;
    n = mn[i];
    for (int k = 0; k < n; k++) begin
      wd = nl(i) ? mw[i][n-1-k] : mw[i][k];
      for (int b = 0; b < iw(i); b++) d[k*iw(i)+b] = wd[b];
    end
    return {6'(n), d};
  endfunction

  // Reference model, evaluated at the negedge on the values the coming posedge will see.
  task automatic model_step(input int i);
    logic sf, er;
    int   w;
    w = nw(i);
    if (rst) begin
      mn[i]  = 0;
      mfp[i] = 1'b0;
      exp_q[i].delete();
      return;
    end
    chk(i, "out_valid", ov[i], exp_q[i].size() != 0);
    if (exp_q[i].size() != 0) chk(i, "packet", {oc[i], od[i]}, exp_q[i][0]);
    sf = (exp_q[i].size() == 0) || ordy[i];
    er = !mfp[i] && ((mn[i] < w - 1) || sf);
    chk(i, "in_ready", ir[i], er);
    if (exp_q[i].size() != 0 && ordy[i]) void'(exp_q[i].pop_front());
    if (iv[i] && er) begin
      mw[i][mn[i]] = id[i];
      mn[i]++;
    end
    if (mn[i] == w) begin
      exp_q[i].push_back(make_pkt(i));
      mn[i]  = 0;
      mfp[i] = fl[i];
    end else if ((fl[i] || mfp[i]) && sf) begin
      if (mn[i] != 0 || ee(i)) exp_q[i].push_back(make_pkt(i));
      mn[i]  = 0;
      mfp[i] = 1'b0;
    end else begin
      mfp[i] = mfp[i] || fl[i];
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) model_step(i);
  end

  // Presents one word (optionally with a flush on its first cycle) until accepted.
  task automatic send(input int i, input logic [15:0] w, input logic f);
    logic rdy;
    rdy   = 1'b0;
    iv[i] = 1'b1;
    id[i] = w;
    fl[i] = f;
    for (int t = 0; t < 200; t++) begin
      rdy = ir[i];
      cyc();
      fl[i] = 1'b0;
      if (rdy === 1'b1) break;
    end
    iv[i] = 1'b0;
    chk(i, "send_done", rdy, 1'b1);
  endtask

  initial begin
    logic [511:0] e;
    logic [7:0]   tw [4];
    row_t         tbl [5];

    for (int i = 0; i < 3; i++) begin
      fl[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b1; id[i] = '0;
    end
    tw[0] = 8'h11; tw[1] = 8'h22; tw[2] = 8'h33; tw[3] = 8'h44;
    tbl[0] = '{4, 1'b0, 1'b0, 32'h11223344, 6'd4};
    tbl[1] = '{3, 1'b0, 1'b1, 32'h00112233, 6'd3};
    tbl[2] = '{2, 1'b1, 1'b0, 32'h00001122, 6'd2};
    tbl[3] = '{1, 1'b0, 1'b1, 32'h00000011, 6'd1};
    tbl[4] = '{0, 1'b0, 1'b1, 32'h00000000, 6'd0};

    repeat (3) cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk(i, "rst_valid", ov[i], 1'b0);
      chk(i, "rst_count", oc[i], 6'd0);
      chk(i, "rst_data", od[i], 512'd0);
      chk(i, "rst_in_ready", ir[i], 1'b1);
    end

    // Full packet, newest word in slot 0.
    for (int j = 0; j < 32; j++) begin
      chk(0, "full_in_ready", ir[0], 1'b1);
      send(0, 16'(j), 1'b0);
    end
    chk(0, "full_valid", ov[0], 1'b1);
    chk(0, "full_count", oc[0], 6'd32);
    chk(0, "full_slot0", od[0][15:0], 16'h001F);
    chk(0, "full_slot31", od[0][511:496], 16'h0000);
    cyc();

    // Partial flush, first word in slot 0.
    send(1, 16'h00A1, 1'b0);
    send(1, 16'h00A2, 1'b0);
    send(1, 16'h00A3, 1'b0);
    chk(1, "partial_pre_valid", ov[1], 1'b0);
    fl[1] = 1'b1; cyc(); fl[1] = 1'b0;
    e = '0;
    e[47:0] = 48'h00A3_00A2_00A1;
    chk(1, "partial_valid", ov[1], 1'b1);
    chk(1, "partial_count", oc[1], 6'd3);
    chk(1, "partial_data", od[1], e);
    cyc();

    // Backpressure: first packet held while the second fills to 31 words.
    ordy[0] = 1'b0;
    for (int j = 0; j < 63; j++) send(0, 16'(32'h100 + j), 1'b0);
    chk(0, "bp_in_ready_full", ir[0], 1'b0);
    chk(0, "bp_held_slot0", od[0][15:0], 16'h011F);
    repeat (3) cyc();
    chk(0, "bp_hold_valid", ov[0], 1'b1);
    chk(0, "bp_hold_slot31", od[0][511:496], 16'h0100);
    iv[0] = 1'b1; id[0] = 16'h013F; ordy[0] = 1'b1;
    cyc();
    iv[0] = 1'b0;
    chk(0, "bp_second_valid", ov[0], 1'b1);
    chk(0, "bp_second_count", oc[0], 6'd32);
    chk(0, "bp_second_slot0", od[0][15:0], 16'h013F);
    chk(0, "bp_second_slot31", od[0][511:496], 16'h0120);
    cyc();

    // Flush with nothing buffered.
    fl[0] = 1'b1; cyc(); fl[0] = 1'b0;
    chk(0, "empty_drop_valid", ov[0], 1'b0);
    cyc();
    chk(0, "empty_drop_valid2", ov[0], 1'b0);
    fl[1] = 1'b1; cyc(); fl[1] = 1'b0;
    chk(1, "empty_emit_valid", ov[1], 1'b1);
    chk(1, "empty_emit_count", oc[1], 6'd0);
    chk(1, "empty_emit_data", od[1], 512'd0);
    cyc();
    chk(1, "empty_emit_done", ov[1], 1'b0);

    // Flush together with the completing word, then with the 5th word.
    for (int j = 0; j < 31; j++) send(0, 16'(32'h300 + j), 1'b0);
    send(0, 16'h031F, 1'b1);
    chk(0, "simul_full_valid", ov[0], 1'b1);
    chk(0, "simul_full_count", oc[0], 6'd32);
    chk(0, "simul_full_slot0", od[0][15:0], 16'h031F);
    cyc();
    chk(0, "simul_no_partial", ov[0], 1'b0);
    cyc();
    chk(0, "simul_no_partial2", ov[0], 1'b0);
    for (int j = 0; j < 4; j++) send(0, 16'(32'h400 + j), 1'b0);
    send(0, 16'h0404, 1'b1);
    chk(0, "simul5_valid", ov[0], 1'b1);
    chk(0, "simul5_count", oc[0], 6'd5);
    chk(0, "simul5_slot0", od[0][15:0], 16'h0404);
    chk(0, "simul5_slot4", od[0][79:64], 16'h0400);
    chk(0, "simul5_slot5", od[0][95:80], 16'h0000);
    cyc();

    // Reset mid-packet discards buffered words.
    for (int j = 0; j < 10; j++) send(0, 16'(32'h500 + j), 1'b0);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk(0, "midrst_valid", ov[0], 1'b0);
    chk(0, "midrst_count", oc[0], 6'd0);
    for (int j = 0; j < 32; j++) send(0, 16'(32'h600 + j), 1'b0);
    chk(0, "midrst_pkt_valid", ov[0], 1'b1);
    chk(0, "midrst_pkt_count", oc[0], 6'd32);
    chk(0, "midrst_slot31", od[0][511:496], 16'h0600);
    chk(0, "midrst_slot0", od[0][15:0], 16'h061F);
    cyc();

    // Small configuration vector table.
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < tbl[r].n; j++)
        send(2, {8'h00, tw[j]}, (j == tbl[r].n - 1) && tbl[r].fl_last);
      if (tbl[r].fl_after) begin
        fl[2] = 1'b1; cyc(); fl[2] = 1'b0;
      end
      chk(2, $sformatf("tbl%0d_valid", r), ov[2], 1'b1);
      chk(2, $sformatf("tbl%0d_count", r), oc[2], tbl[r].exp_cnt);
      chk(2, $sformatf("tbl%0d_data", r), od[2][31:0], tbl[r].exp_data);
      cyc();
    end

    // Random traffic on all instances, checked by the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        iv[i]   = ($urandom_range(0, 3) != 0);
        id[i]   = 16'($urandom);
        fl[i]   = ($urandom_range(0, 40) == 0);
        ordy[i] = ($urandom_range(0, 3) != 0);
      end
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; fl[i] = 1'b0; ordy[i] = 1'b1;
    end
    repeat (5) cyc();
    for (int i = 0; i < 3; i++) begin
      chk(i, "drain_queue", exp_q[i].size(), 0);
      chk(i, "drain_valid", ov[i], 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
